// File: rtl/device_sel_pkg.sv
// Shared definitions for the input device selector: auto-mode FSM
// states, mode encodings and a lowest-set-bit priority helper.
package device_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_OPEN   = 2'd2
    } sel_state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Widest channel count the selector supports.
    localparam int MAX_CH = 8;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [MAX_CH-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (v[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sel_timer.sv
// Loadable down-counter that stops at zero instead of wrapping.
// Ports: i_clk, i_reset (sync, active-high), i_clear, i_load,
//        i_load_val [W-1:0], o_zero (count is zero).
module sel_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear beats load; otherwise count down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/input_device_selector.sv
// Selects one of N_CH input device channels, manually (i_sel) or by activity.
// Ports: i_clk, i_reset (sync, active-high), i_data [N_CH*WIDTH], i_valid [N_CH],
//        i_mode (0 manual / 1 auto), i_sel, o_data, o_active_ch, o_idle, o_switch.
// Macro SELECTOR_HOLD_EN: o_data shows each channel's last captured sample
// instead of the live channel data.
module input_device_selector
    import device_sel_pkg::*;
#(
    parameter int               N_CH           = 4,
    parameter int               WIDTH          = 14,
    parameter int               HOLD_CYCLES    = 50_000_000,
    parameter int               TIMEOUT_CYCLES = 250_000_000,
    parameter logic [WIDTH-1:0] DEFAULT_DATA   = '1,
    localparam int              SEL_W          = $clog2(N_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_CH*WIDTH-1:0] i_data,
    input  logic [N_CH-1:0]       i_valid,
    input  logic                  i_mode,
    input  logic [SEL_W-1:0]      i_sel,
    output logic [WIDTH-1:0]      o_data,
    output logic [SEL_W-1:0]      o_active_ch,
    output logic                  o_idle,
    output logic                  o_switch
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    sel_state_e       state_q, state_d;
    logic             mode_q;
    logic [SEL_W-1:0] active_q, active_d;
    logic             idle_q, idle_d;
    logic             switch_q, switch_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             auto_run;
    logic             load_both;
    logic             reload_to;
    logic [SEL_W-1:0] sel_ch;
    logic [N_CH-1:0]  others;
    logic             hold_zero;
    logic             to_zero;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] ch_data [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_data[k] = i_data[k*WIDTH +: WIDTH];
    end

    // A mode change (or manual mode) parks the FSM in IDLE for the cycle.
    assign auto_run = (i_mode == MODE_AUTO) && (i_mode == mode_q);

    sel_timer #(.W(TW)) u_hold (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (!auto_run),
        .i_load     (load_both),
        .i_load_val (TW'(HOLD_CYCLES)),
        .o_zero     (hold_zero)
    );

    sel_timer #(.W(TW)) u_timeout (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (!auto_run),
        .i_load     (load_both || reload_to),
        .i_load_val (TW'(TIMEOUT_CYCLES)),
        .o_zero     (to_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= i_mode;
            active_q <= '0;
            idle_q   <= 1'b1;
            switch_q <= 1'b0;
            data_q   <= DEFAULT_DATA;
        end else begin
            state_q  <= state_d;
            mode_q   <= i_mode;
            active_q <= active_d;
            idle_q   <= idle_d;
            switch_q <= switch_d;
            data_q   <= data_d;
        end
    end

    // Next state; the selected channel's strobe outranks everyone else.
    always_comb begin
        state_d   = state_q;
        load_both = 1'b0;
        reload_to = 1'b0;
        sel_ch    = active_q;
        others    = i_valid;
        others[active_q] = 1'b0;
        if (!auto_run) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|i_valid) begin
                        sel_ch    = SEL_W'(lowest_set(MAX_CH'(i_valid)));
                        load_both = 1'b1;
                        state_d   = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (to_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        reload_to = i_valid[active_q];
                        if (hold_zero) begin
                            state_d = ST_OPEN;
                        end
                    end
                end
                ST_OPEN: begin
                    if (to_zero) begin
                        state_d = ST_IDLE;
                    end else if (i_valid[active_q]) begin
                        reload_to = 1'b1;
                    end else if (|others) begin
                        sel_ch    = SEL_W'(lowest_set(MAX_CH'(others)));
                        load_both = 1'b1;
                        state_d   = ST_LOCKED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef SELECTOR_HOLD_EN
    logic [WIDTH-1:0] cap_q [N_CH];

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (i_reset) begin
                cap_q[k] <= '0;
            end else if (i_valid[k]) begin
                cap_q[k] <= ch_data[k];
            end
        end
    end

    // A sample arriving this cycle is shown at once, not a cycle late.
    assign pick = i_valid[active_d] ? ch_data[active_d] : cap_q[active_d];
`else
    assign pick = ch_data[active_d];
`endif

    // Registered outputs; manual mode follows i_sel directly.
    always_comb begin
        active_d = (i_mode == MODE_MANUAL) ? i_sel : sel_ch;
        idle_d   = (i_mode == MODE_AUTO) && (state_d == ST_IDLE);
        switch_d = (active_d != active_q) || (idle_q && !idle_d);
        data_d   = idle_d ? DEFAULT_DATA : pick;
    end

    assign o_data      = data_q;
    assign o_active_ch = active_q;
    assign o_idle      = idle_q;
    assign o_switch    = switch_q;

endmodule

// File: tb/tb_input_device_selector.sv
// Randomised and directed bench for input_device_selector with a
// time-stamp based reference model of the channel selection rules.
module tb_input_device_selector;

    localparam int N_CH  = 4;
    localparam int WIDTH = 14;
    localparam int HOLD  = 10;
    localparam int TMO   = 40;
    localparam int DEF   = 'h3FFF;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [55:0] i_data;
    logic [3:0]  i_valid;
    logic        i_mode;
    logic [1:0]  i_sel;
    logic [13:0] o_data;
    logic [1:0]  o_active_ch;
    logic        o_idle;
    logic        o_switch;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    input_device_selector #(
        .N_CH           (N_CH),
        .WIDTH          (WIDTH),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_mode      (i_mode),
        .i_sel       (i_sel),
        .o_data      (o_data),
        .o_active_ch (o_active_ch),
        .o_idle      (o_idle),
        .o_switch    (o_switch)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    function automatic int chan(input int k);
        return int'(i_data[k*WIDTH +: WIDTH]);
    endfunction

    // Model: a selection is remembered by the cycle it happened (t_sel)
    // and the cycle its timeout was last refreshed (t_ref).
    int  cyc = 0;
    int  m_sel, t_sel, t_ref, psel;
    bit  m_idle, m_aidle, m_mode, pidle;
    bit  mdl_ok = 1'b0;
    int  e_sel, e_idle, e_sw, e_data;
    int  cap [4];
    logic [3:0] oth;

    always @(posedge clk) begin
        psel  = m_sel;
        pidle = m_idle;
        if (i_reset) begin
            m_sel   = 0;
            m_idle  = 1'b1;
            m_aidle = 1'b1;
            m_mode  = i_mode;
            for (int k = 0; k < 4; k++) cap[k] = 0;
            e_sel  = 0;
            e_idle = 1;
            e_sw   = 0;
            e_data = DEF;
            mdl_ok = 1'b1;
        end else begin
            oth = i_valid;
            oth[m_sel] = 1'b0;
            if (i_mode != m_mode) begin
                m_mode  = i_mode;
                m_aidle = 1'b1;
                if (i_mode) begin
                    m_idle = 1'b1;
                end else begin
                    m_sel  = int'(i_sel);
                    m_idle = 1'b0;
                end
            end else if (!i_mode) begin
                m_sel  = int'(i_sel);
                m_idle = 1'b0;
            end else if (m_aidle) begin
                if (i_valid != 4'b0) begin
                    m_sel   = lowest(i_valid);
                    m_aidle = 1'b0;
                    m_idle  = 1'b0;
                    t_sel   = cyc;
                    t_ref   = cyc;
                end
            end else if (cyc - t_ref >= TMO + 1) begin
                m_aidle = 1'b1;
                m_idle  = 1'b1;
            end else if (i_valid[m_sel]) begin
                t_ref = cyc;
            end else if (cyc - t_sel >= HOLD + 2 && oth != 4'b0) begin
                m_sel = lowest(oth);
                t_sel = cyc;
                t_ref = cyc;
            end
            e_sel  = m_sel;
            e_idle = int'(m_idle);
            e_sw   = int'((m_sel != psel) || (pidle && !m_idle));
`ifdef SELECTOR_HOLD_EN
            e_data = m_idle ? DEF : (i_valid[m_sel] ? chan(m_sel) : cap[m_sel]);
`else
            e_data = m_idle ? DEF : chan(m_sel);
`endif
            for (int k = 0; k < 4; k++) begin
                if (i_valid[k]) cap[k] = chan(k);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("m_ch",   int'(o_active_ch), e_sel);
            chk("m_idle", int'(o_idle),      e_idle);
            chk("m_sw",   int'(o_switch),    e_sw);
            chk("m_data", int'(o_data),      e_data);
        end
    end

    task automatic drive(input logic [3:0] v, input logic [13:0] d2);
        @(negedge clk);
        i_valid = v;
        i_data  = 56'({$urandom(), $urandom()});
        i_data[2*WIDTH +: WIDTH] = d2;
    endtask

    int k;
    int dens;

    initial begin
        i_reset = 1'b1;
        i_mode  = 1'b1;
        i_sel   = 2'd0;
        i_valid = 4'b0;
        i_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_idle", int'(o_idle),      1);
        chk("rst_ch",   int'(o_active_ch), 0);
        chk("rst_sw",   int'(o_switch),    0);
        chk("rst_data", int'(o_data),      DEF);
        i_reset = 1'b0;

        drive(4'b0100, 14'h0055);
        drive(4'b0000, 14'h0);
        chk("sel2_ch",   int'(o_active_ch), 2);
        chk("sel2_idle", int'(o_idle),      0);
        chk("sel2_sw",   int'(o_switch),    1);
        chk("sel2_data", int'(o_data),      'h55);

        repeat (3) drive(4'b0000, 14'h0);
        drive(4'b0010, 14'h0);
        drive(4'b0000, 14'h0);
        chk("lock_ch", int'(o_active_ch), 2);
        chk("lock_sw", int'(o_switch),    0);
        repeat (5) drive(4'b0000, 14'h0);
        drive(4'b0010, 14'h0);
        drive(4'b0000, 14'h0);
        chk("open_ch", int'(o_active_ch), 1);
        chk("open_sw", int'(o_switch),    1);

        for (k = 2; k < 70; k++) begin
            drive(4'b0000, 14'h0);
            if (o_idle) break;
        end
        chk("to_len",  k, 42);
        chk("to_data", int'(o_data), DEF);

        drive(4'b0100, 14'h0123);
        repeat (11) drive(4'b0000, 14'h0);
        drive(4'b1110, 14'h0777);
        drive(4'b0000, 14'h0);
        chk("own_ch", int'(o_active_ch), 2);
        chk("own_sw", int'(o_switch),    0);
        for (k = 14; k < 90; k++) begin
            drive(4'b0000, 14'h0);
            if (o_idle) break;
        end
        chk("reload_len", k, 54);

        drive(4'b0000, 14'h0);
        i_mode = 1'b0;
        i_sel  = 2'd3;
        drive(4'b0000, 14'h0);
        chk("man_ch",   int'(o_active_ch), 3);
        chk("man_idle", int'(o_idle),      0);
        i_mode = 1'b1;
        drive(4'b0000, 14'h0);
        chk("tog_idle", int'(o_idle),   1);
        chk("tog_sw",   int'(o_switch), 0);

        drive(4'b0010, 14'h0);
        repeat (3) drive(4'b0000, 14'h0);
        i_reset = 1'b1;
        drive(4'b0000, 14'h0);
        chk("mid_idle", int'(o_idle),      1);
        chk("mid_ch",   int'(o_active_ch), 0);
        chk("mid_sw",   int'(o_switch),    0);
        chk("mid_data", int'(o_data),      DEF);
        i_reset = 1'b0;

        for (int n = 0; n < 4500; n++) begin
            dens = (n < 1500) ? 7 : ((n < 3000) ? 1 : 60);
            @(negedge clk);
            i_data  = 56'({$urandom(), $urandom()});
            i_valid = ($urandom_range(0, dens) == 0) ? 4'($urandom()) : 4'b0;
            if ($urandom_range(0, 199) == 0) i_mode = ~i_mode;
            if ($urandom_range(0, 15) == 0) i_sel = 2'($urandom());
            i_reset = ($urandom_range(0, 999) == 0);
        end
        i_reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/input_device_selector.md
INPUT_DEVICE_SELECTOR -- requirements
Module: input_device_selector

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input device channels, 2..8.
REQ-002 SHALL have parameter WIDTH, default 14: per-channel data width.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000: minimum dwell on a channel before auto-switch (1 s at 50 MHz); >=1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 250_000_000: inactivity window before auto return to idle; > HOLD_CYCLES.
REQ-005 SHALL have parameter DEFAULT_DATA, default all-ones: o_data value when idle.
REQ-006 SHALL have port i_clk  in  1  50 MHz system clock; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port i_reset  in  1  synchronous active-high reset.
REQ-008 SHALL have port i_data  in  N_CH*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port i_valid  in  N_CH  one-cycle new-data strobe per channel.
REQ-010 SHALL have port i_mode  in  1  0 = manual select, 1 = auto (activity-driven) select.
REQ-011 SHALL have port i_sel  in  SEL_W ($clog2(N_CH))  manual channel index.
REQ-012 SHALL have port o_data  out  WIDTH  selected, registered data.
REQ-013 SHALL have port o_active_ch  out  SEL_W  currently selected channel.
REQ-014 SHALL have port o_idle  out  1  high while no channel is selected (auto IDLE).
REQ-015 SHALL have port o_switch  out  1  one-cycle pulse on every change of o_active_ch or idle->selected.

Function
REQ-016 Manual mode: o_active_ch SHALL equal i_sel registered, 1-cycle latency; o_idle=0; timers held cleared.
REQ-017 Auto FSM states SHALL be IDLE, LOCKED, OPEN.
REQ-018 IDLE: on any i_valid, SHALL select lowest-index asserted channel, load hold timer with HOLD_CYCLES and timeout timer with TIMEOUT_CYCLES, go LOCKED.
REQ-019 LOCKED: other channels' strobes SHALL be ignored; selected-channel strobe SHALL reload timeout timer only; go OPEN when hold timer reaches 0.
REQ-020 OPEN: strobe on another channel SHALL switch to it (lowest index among non-selected if several), reload both timers, go LOCKED.
REQ-021 Simultaneous strobes on the selected channel and others in OPEN: selected channel SHALL win; no switch; timeout reloaded.
REQ-022 LOCKED or OPEN: timeout timer reaching 0 SHALL go IDLE, o_data=DEFAULT_DATA, o_idle=1.
REQ-023 Change of i_mode SHALL force FSM to IDLE on the next cycle; o_switch pulses only if o_active_ch changes.
REQ-024 o_data SHALL update one cycle after the selecting event; no combinational path from inputs to outputs.
REQ-025 Timers SHALL saturate at 0, never wrap.

Reset
REQ-026 On i_reset: FSM=IDLE, o_active_ch=0, o_idle=1, o_switch=0, o_data=DEFAULT_DATA, timers=0, captured data cleared; reset mid-dwell SHALL abandon dwell with no o_switch pulse.

Configuration
REQ-027 Macro SELECTOR_HOLD_EN defined: per-channel register captures i_data on i_valid; o_data shows the selected channel's last captured value.
REQ-028 Macro SELECTOR_HOLD_EN undefined: o_data SHALL be the selected channel's live i_data, registered each cycle; no capture registers.

Structure
REQ-029 Package device_sel_pkg SHALL hold the FSM state enum and MODE_MANUAL/MODE_AUTO constants.
REQ-030 Sub-module sel_timer (loadable saturating down-counter, parametrised width) SHALL be instantiated twice: hold and timeout.

Verification (bench uses HOLD_CYCLES=10, TIMEOUT_CYCLES=40, N_CH=4, WIDTH=14)
REQ-031 Auto, pulse i_valid[2] with data 0x0055 -> next cycle o_active_ch=2, o_idle=0, o_switch=1, o_data=0x0055.
REQ-032 Auto, ch2 selected, i_valid[1] at cycle 5 then again at cycle 12 -> no switch at 5; switch to ch1 at 13.
REQ-033 OPEN on ch2, i_valid=4'b1110 -> ch2 retained, timeout reloaded, o_switch=0.
REQ-034 No strobe for 40 cycles after selection -> o_idle=1, o_data=0x3FFF.
REQ-035 Manual, i_sel=3 -> o_active_ch=3 one cycle later; toggling i_mode to auto -> o_idle=1 next cycle.
REQ-036 i_reset asserted mid-LOCKED -> all outputs at reset values next cycle, o_switch=0.
